keypad_encoder: RTL and testbench
=================================

Name: keypad_encoder

Overview:
- Front end of the timer datapath; the reverse direction of the 7-segment display decoder.
- Accepts raw 10-key keypad lines and debounces them.
- Encodes each accepted key to BCD and shifts it right-to-left into a 3-digit M:SS entry register (Minutos, DezenaSeg, UnidadeSeg).
- These registers drive the countdown/timer load path and the display decoder.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive samples of the same single key required for acceptance (legal range 1..15)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
Keypad  input  10  key lines, bit i high = digit i pressed
Enable  input  1  entry permitted (low while timer runs / door open)
Clear  input  1  synchronous clear of the entry register
Minutos  output  4  BCD minutes digit
DezenaSeg  output  4  BCD seconds-tens digit
UnidadeSeg  output  4  BCD seconds-units digit
DataValid  output  1  one-cycle pulse: a digit was accepted this cycle
Erro  output  1  one-cycle pulse: a digit was rejected (LIMIT_TEMPO_EN only, else tied 0)

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous, active-high. All outputs are registered.
- Reset values: Minutos, DezenaSeg and UnidadeSeg = 0; DataValid = 0; Erro = 0; FSM = IDLE; debounce counter = 0.
- Priority order: reset > Clear > Enable=0 > FSM.
- "Single key" means Keypad is exactly one-hot. Zero keys or two or more keys is never a candidate.
- FSM states: IDLE, DEBOUNCE, HOLD.
  - IDLE: if Keypad is single key i, latch cand = i and cnt = 1. If DEBOUNCE_CYCLES == 1, accept immediately and go to HOLD; otherwise go to DEBOUNCE. Else stay in IDLE.
  - DEBOUNCE: if Keypad == onehot(cand), cnt++. When the count reaches DEBOUNCE_CYCLES, accept and go to HOLD. Any other Keypad value (including 0 or multiple keys) returns to IDLE with cnt = 0; no output change.
  - HOLD: stay until Keypad == 0 for one sample, then go to IDLE. No new acceptance while held, so auto-repeat is forbidden.
- Accept: Minutos <= DezenaSeg; DezenaSeg <= UnidadeSeg; UnidadeSeg <= cand (4-bit BCD 0..9). Old Minutos is discarded.
- Latency: key first sampled at edge k and held. Digit registers update and DataValid = 1 at edge k+DEBOUNCE_CYCLES-1, visible for exactly one cycle.
- Clear: digits <= 0; FSM <= HOLD (a key held during Clear is not entered); DataValid/Erro <= 0.
- Enable = 0: digits frozen; FSM forced to HOLD; cnt = 0. After Enable rises, all keys must be released before the next entry.
- Reset or Clear mid-debounce: the pending candidate is discarded; no DataValid.
- DataValid and Erro are never high in the same cycle.

Optional Feature:
- Macro: LIMIT_TEMPO_EN.
- Defined: on accept, if the value shifting into DezenaSeg (old UnidadeSeg) is > 5, the shift is suppressed. Digits are unchanged, Erro pulses 1 cycle instead of DataValid, and the FSM still goes to HOLD. This guarantees seconds 00..59.
- Undefined: every debounced digit is accepted, and Erro is constant 0.

Test Plan:
- Reset then entry of 1, 2, 3, each held 6 cycles and released 3 cycles (DEBOUNCE_CYCLES=4) -> three DataValid pulses, each 3 edges after key onset; final Minutos=1, DezenaSeg=2, UnidadeSeg=3.
- Glitch: key 7 high 2 cycles, low 1, high 2 -> no DataValid; digits unchanged.
- Keys 2 and 5 high together for 10 cycles -> no acceptance. Then key 5 alone held 20 cycles -> exactly one DataValid, UnidadeSeg=5.
- Entry 4,5,6,7 -> digits 5,6,7 (4 shifted out). Then Clear while key 8 is held -> all digits 0. Releasing and re-pressing 8 -> UnidadeSeg=8.
- Enable=0 while key 3 is held 10 cycles -> no change. Enable=1 with key still held -> no entry until release and re-press. Reset asserted mid-debounce -> all outputs 0, no DataValid.
- With LIMIT_TEMPO_EN: enter 1 then 7, then press 2 -> Erro pulse; digits stay 0,1,7. Without the macro -> DataValid; digits become 1,7,2.

Source files
------------

// File: rtl/keypad_encoder_if.sv
// Keypad entry bus: raw key lines and entry controls in, BCD M:SS digits and strobes out.
interface keypad_encoder_if;
  logic [9:0] Keypad;
  logic       Enable;
  logic       Clear;
  logic [3:0] Minutos;
  logic [3:0] DezenaSeg;
  logic [3:0] UnidadeSeg;
  logic       DataValid;
  logic       Erro;

  modport master (
    output Keypad, Enable, Clear,
    input  Minutos, DezenaSeg, UnidadeSeg, DataValid, Erro
  );

  modport slave (
    input  Keypad, Enable, Clear,
    output Minutos, DezenaSeg, UnidadeSeg, DataValid, Erro
  );
endinterface

// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to BCD M:SS entry register (shifts digits in right-to-left).
// Optional macro LIMIT_TEMPO_EN rejects entries that would put a value above 5 in DezenaSeg.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic            clock,
  input logic            reset,
  keypad_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} state_t;

  localparam logic [3:0] DC = 4'(DEBOUNCE_CYCLES);

  state_t     state;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic [3:0] minutos;
  logic [3:0] dezena_seg;
  logic [3:0] unidade_seg;
  logic       data_valid;
  logic       erro;

  logic       single_key;
  logic [3:0] key_index;
  logic       accept;
  logic [3:0] accept_digit;

  always_comb begin
    key_index = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.Keypad[i]) key_index = 4'(i);
    end
    single_key = (bus.Keypad != 10'd0) && ((bus.Keypad & (bus.Keypad - 10'd1)) == 10'd0);
  end

  // A digit is accepted on the sample that completes the run of identical single-key samples.
  always_comb begin
    accept       = 1'b0;
    accept_digit = cand;
    case (state)
      IDLE: begin
        if (single_key && DC == 4'd1) begin
          accept       = 1'b1;
          accept_digit = key_index;
        end
      end
      DEBOUNCE: begin
        if (bus.Keypad == (10'd1 << cand) && (cnt + 4'd1) == DC) accept = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= 4'd0;
      cnt         <= 4'd0;
      minutos     <= 4'd0;
      dezena_seg  <= 4'd0;
      unidade_seg <= 4'd0;
      data_valid  <= 1'b0;
      erro        <= 1'b0;
    end else if (bus.Clear) begin
      state       <= HOLD;
      cnt         <= 4'd0;
      minutos     <= 4'd0;
      dezena_seg  <= 4'd0;
      unidade_seg <= 4'd0;
      data_valid  <= 1'b0;
      erro        <= 1'b0;
    end else if (!bus.Enable) begin
      state      <= HOLD;
      cnt        <= 4'd0;
      data_valid <= 1'b0;
      erro       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      erro       <= 1'b0;
      if (accept) begin
`ifdef LIMIT_TEMPO_EN
        if (unidade_seg > 4'd5) begin
          erro <= 1'b1;
        end else begin
          minutos     <= dezena_seg;
          dezena_seg  <= unidade_seg;
          unidade_seg <= accept_digit;
          data_valid  <= 1'b1;
        end
`else
        minutos     <= dezena_seg;
        dezena_seg  <= unidade_seg;
        unidade_seg <= accept_digit;
        data_valid  <= 1'b1;
`endif
      end
      case (state)
        IDLE: begin
          if (single_key) begin
            cand  <= key_index;
            cnt   <= 4'd1;
            state <= accept ? HOLD : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (bus.Keypad == (10'd1 << cand)) begin
            cnt   <= accept ? 4'd0 : cnt + 4'd1;
            state <= accept ? HOLD : DEBOUNCE;
          end else begin
            cnt   <= 4'd0;
            state <= IDLE;
          end
        end
        HOLD: begin
          cnt <= 4'd0;
          if (bus.Keypad == 10'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Minutos    = minutos;
  assign bus.DezenaSeg  = dezena_seg;
  assign bus.UnidadeSeg = unidade_seg;
  assign bus.DataValid  = data_valid;
  assign bus.Erro       = erro;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed entry scenarios then random key traffic,
// compared every cycle against a numeric M:SS entry model. Honours LIMIT_TEMPO_EN.
module tb_keypad_encoder;

  localparam int DC = 4;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  keypad_encoder_if bus();

  keypad_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference state: the entry is just a number 0..999, digits are its decimal places.
  int model_value;
  bit model_armed;
  int streak;
  int streak_key;
  bit exp_dv;
  bit exp_erro;

  function automatic logic [9:0] key(input int i);
    logic [9:0] one;
    one = 10'd1;
    return one << i;
  endfunction

  function automatic int key_of(input logic [9:0] k);
    int idx;
    idx = -1;
    for (int i = 0; i < 10; i++) if (k[i]) idx = i;
    return idx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelAccept(input int k);
`ifdef LIMIT_TEMPO_EN
    if (model_value % 10 > 5) exp_erro = 1'b1;
    else begin
      model_value = (model_value * 10 + k) % 1000;
      exp_dv = 1'b1;
    end
`else
    model_value = (model_value * 10 + k) % 1000;
    exp_dv = 1'b1;
`endif
  endtask

  // A key counts once it is seen alone DC samples in a row after a full release; a different
  // key interrupting a run only aborts it, so the new key starts counting on the next sample.
  task automatic modelStep();
    int k;
    exp_dv   = 1'b0;
    exp_erro = 1'b0;
    if (reset) begin
      model_value = 0;
      model_armed = 1'b1;
      streak      = 0;
    end else if (bus.Clear) begin
      model_value = 0;
      model_armed = 1'b0;
      streak      = 0;
    end else if (!bus.Enable) begin
      model_armed = 1'b0;
      streak      = 0;
    end else if (!model_armed) begin
      if (bus.Keypad == 10'd0) model_armed = 1'b1;
      streak = 0;
    end else if ($countones(bus.Keypad) == 1) begin
      k = key_of(bus.Keypad);
      if (streak > 0 && k == streak_key) streak++;
      else if (streak > 0) streak = 0;
      else begin
        streak     = 1;
        streak_key = k;
      end
      if (streak == DC) begin
        modelAccept(k);
        model_armed = 1'b0;
        streak      = 0;
      end
    end else begin
      streak = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    @(negedge clock);
    checkOutput("DataValid",  32'(bus.DataValid),  32'(exp_dv));
    checkOutput("Erro",       32'(bus.Erro),       32'(exp_erro));
    checkOutput("Minutos",    32'(bus.Minutos),    32'(model_value / 100));
    checkOutput("DezenaSeg",  32'(bus.DezenaSeg),  32'((model_value / 10) % 10));
    checkOutput("UnidadeSeg", 32'(bus.UnidadeSeg), 32'(model_value % 10));
  endtask

  task automatic applyStimulus(input logic [9:0] keys, input int cycles);
    bus.Keypad = keys;
    repeat (cycles) tick();
  endtask

  task automatic pressDigit(input int d);
    applyStimulus(key(d), 6);
    applyStimulus(10'd0, 3);
  endtask

  task automatic checkDigits(input string tag, input int m, input int d, input int u);
    checkOutput({tag, " Minutos"},    32'(bus.Minutos),    32'(m));
    checkOutput({tag, " DezenaSeg"},  32'(bus.DezenaSeg),  32'(d));
    checkOutput({tag, " UnidadeSeg"}, 32'(bus.UnidadeSeg), 32'(u));
  endtask

  initial begin
    int dv_seen;
    int dv_cycle;
    bus.Keypad = 10'd0;
    bus.Enable = 1'b1;
    bus.Clear  = 1'b0;
    reset      = 1'b1;
    model_value = 0;
    model_armed = 1'b1;
    streak      = 0;
    streak_key  = 0;
    repeat (2) tick();
    checkDigits("reset", 0, 0, 0);
    reset = 1'b0;

    // Entry latency: DataValid appears on the 4th edge counting the onset edge.
    bus.Keypad = key(1);
    dv_cycle = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.DataValid && dv_cycle < 0) dv_cycle = c;
    end
    checkOutput("latency edge", 32'(dv_cycle), 32'(DC));
    applyStimulus(10'd0, 3);
    pressDigit(2);
    pressDigit(3);
    checkDigits("seq123", 1, 2, 3);

    // Glitchy key 7 never accumulates enough stable samples.
    applyStimulus(key(7), 2);
    applyStimulus(10'd0, 1);
    applyStimulus(key(7), 2);
    applyStimulus(10'd0, 3);
    checkDigits("glitch", 1, 2, 3);

    // Two keys together are ignored; then key 5 alone gives exactly one entry.
    applyStimulus(key(2) | key(5), 10);
    checkDigits("multikey", 1, 2, 3);
    bus.Keypad = key(5);
    dv_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.DataValid) dv_seen++;
    end
    checkOutput("hold one pulse", 32'(dv_seen), 32'd1);
    applyStimulus(10'd0, 3);
    checkDigits("key5", 2, 3, 5);

    pressDigit(4);
    pressDigit(5);
    pressDigit(6);
    pressDigit(7);
    checkDigits("seq4567", 5, 6, 7);

    // Clear while 8 is held: cleared, and the held 8 is not entered.
    bus.Keypad = key(8);
    repeat (2) tick();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    applyStimulus(key(8), 6);
    checkDigits("clear", 0, 0, 0);
    applyStimulus(10'd0, 3);
    pressDigit(8);
    checkDigits("after clear", 0, 0, 8);

    // Entry disabled while 3 held; re-enabling with 3 still down must not enter it.
    bus.Enable = 1'b0;
    applyStimulus(key(3), 10);
    bus.Enable = 1'b1;
    applyStimulus(key(3), 8);
    checkDigits("enable low", 0, 0, 8);
    applyStimulus(10'd0, 3);
    pressDigit(3);
    checkDigits("enable re-press", 0, 8, 3);

    // Reset in the middle of debouncing key 9.
    applyStimulus(key(9), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(key(9), 1);
    applyStimulus(10'd0, 3);
    checkDigits("reset mid", 0, 0, 0);

    // Entering 2 after 1,7 would put 7 into the seconds-tens place.
    pressDigit(1);
    pressDigit(7);
    bus.Keypad = key(2);
    dv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.Erro) dv_seen++;
    end
    applyStimulus(10'd0, 3);
`ifdef LIMIT_TEMPO_EN
    checkOutput("limit erro", 32'(dv_seen), 32'd1);
    checkDigits("limit", 0, 1, 7);
`else
    checkOutput("no limit erro", 32'(dv_seen), 32'd0);
    checkDigits("no limit", 1, 7, 2);
`endif

    // Random key traffic including chords, direct key swaps, clears and disables.
    for (int s = 0; s < 400; s++) begin
      int sel;
      int dur;
      sel = int'($urandom_range(99, 0));
      dur = int'($urandom_range(8, 1));
      if (sel < 55) applyStimulus(key(int'($urandom_range(9, 0))), dur);
      else if (sel < 80) applyStimulus(10'd0, dur);
      else if (sel < 90) applyStimulus(key(int'($urandom_range(9, 0))) | key(int'($urandom_range(9, 0))), dur);
      else if (sel < 95) begin
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
      end else begin
        bus.Enable = 1'b0;
        applyStimulus(bus.Keypad, dur);
        bus.Enable = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
